// File: rtl/threshold_monitor_16bit.sv
// threshold_monitor_16bit: classifies samples against thr_lo/thr_hi, debounces and commits a zone.
// Ports: clk, rst (sync active-high); sample_valid/sample in; thr_hi/thr_lo thresholds;
// clear_count zeroes event_count; zone/zone_valid committed zone; change_pulse one-cycle
// commit-change strobe; event_count saturating change count.
// THRESHOLD_MONITOR_STICKY_EN adds sticky seen_above/seen_below outputs.
module threshold_monitor_16bit #(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  input  logic             clear_count,
`ifdef THRESHOLD_MONITOR_STICKY_EN
  output logic             seen_above,
  output logic             seen_below,
`endif
  output logic [1:0]       zone,
  output logic             zone_valid,
  output logic             change_pulse,
  output logic [15:0]      event_count
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [1:0] BELOW = 2'b00, INSIDE = 2'b01, ABOVE = 2'b10;
  localparam logic [CW-1:0] RUN_MAX = CW'(DEBOUNCE);
  logic [1:0]    r_cand;
  logic [CW-1:0] r_run;
  logic [1:0]    w_raw;
  logic [CW-1:0] w_run_next;
  logic          w_commit;
  logic          w_change;
  always_comb begin
    w_raw      = (sample > thr_hi) ? ABOVE : (sample < thr_lo) ? BELOW : INSIDE;
    w_run_next = (w_raw != r_cand) ? CW'(1) : (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
    w_commit   = sample_valid && (w_run_next == RUN_MAX);
    // the committed zone is always the raw class: a commit implies raw == new candidate
    w_change   = w_commit && (!zone_valid || (w_raw != zone));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand       <= INSIDE;
      r_run        <= '0;
      zone         <= INSIDE;
      zone_valid   <= 1'b0;
      change_pulse <= 1'b0;
      event_count  <= '0;
    end else begin
      if (sample_valid) begin
        r_cand <= w_raw;
        r_run  <= w_run_next;
      end
      if (w_commit) begin
        zone       <= w_raw;
        zone_valid <= 1'b1;
      end
      change_pulse <= w_change;
      event_count  <= clear_count ? {15'd0, w_change} :
                      (w_change && event_count != 16'hFFFF) ? event_count + 16'd1 : event_count;
    end
  end
`ifdef THRESHOLD_MONITOR_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_above <= 1'b0;
      seen_below <= 1'b0;
    end else begin
      seen_above <= (w_commit && w_raw == ABOVE) || (seen_above && !clear_count);
      seen_below <= (w_commit && w_raw == BELOW) || (seen_below && !clear_count);
    end
  end
`endif
endmodule

// File: tb/tb_threshold_monitor_16bit.sv
// tb_threshold_monitor_16bit: directed self-checking bench for threshold_monitor_16bit.
module tb_threshold_monitor_16bit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample = '0;
  logic [15:0] thr_hi = 16'h8000;
  logic [15:0] thr_lo = 16'h1000;
  logic        clear_count = 1'b0;
  logic [1:0]  zone;
  logic        zone_valid;
  logic        change_pulse;
  logic [15:0] event_count;
`ifdef THRESHOLD_MONITOR_STICKY_EN
  logic        seen_above;
  logic        seen_below;
`endif
  int tests = 0;
  int fails = 0;
  threshold_monitor_16bit #(.WIDTH(16), .DEBOUNCE(4)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clear_count(clear_count),
`ifdef THRESHOLD_MONITOR_STICKY_EN
    .seen_above(seen_above), .seen_below(seen_below),
`endif
    .zone(zone), .zone_valid(zone_valid), .change_pulse(change_pulse),
    .event_count(event_count)
  );
  always #5 clk = ~clk;
  task automatic step(input logic v, input logic [15:0] s, input logic c);
    @(negedge clk);
    sample_valid = v;
    sample       = s;
    clear_count  = c;
    @(posedge clk);
    #1;
  endtask
  task automatic rep(input int n, input logic [15:0] s);
    for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic expect_state(input string tag, input logic [1:0] z, input logic zv,
                              input logic cp, input logic [15:0] ec);
    chk({tag, ".zone"}, {14'd0, zone}, {14'd0, z});
    chk({tag, ".zone_valid"}, {15'd0, zone_valid}, {15'd0, zv});
    chk({tag, ".change_pulse"}, {15'd0, change_pulse}, {15'd0, cp});
    chk({tag, ".event_count"}, event_count, ec);
  endtask
  initial begin
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    expect_state("reset", 2'b01, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    rep(3, 16'h4000);
    expect_state("t1_pre", 2'b01, 1'b0, 1'b0, 16'd0);
    rep(1, 16'h4000);
    expect_state("t1_commit", 2'b01, 1'b1, 1'b1, 16'd1);
    step(1'b0, 16'h0, 1'b0);
    expect_state("t1_after", 2'b01, 1'b1, 1'b0, 16'd1);
    rep(3, 16'h9000);
    expect_state("t2_three", 2'b01, 1'b1, 1'b0, 16'd1);
    rep(1, 16'h4000);
    rep(3, 16'h9000);
    expect_state("t2_broken", 2'b01, 1'b1, 1'b0, 16'd1);
    rep(1, 16'h9000);
    expect_state("t2_commit", 2'b10, 1'b1, 1'b1, 16'd2);
    rep(4, 16'h8000);
    expect_state("t3_eq_hi", 2'b01, 1'b1, 1'b1, 16'd3);
    rep(1, 16'h8000);
    expect_state("t3_recommit", 2'b01, 1'b1, 1'b0, 16'd3);
    rep(4, 16'h8001);
    expect_state("t3_above", 2'b10, 1'b1, 1'b1, 16'd4);
    rep(4, 16'h1000);
    expect_state("t3_eq_lo", 2'b01, 1'b1, 1'b1, 16'd5);
    rep(4, 16'h0FFF);
    expect_state("t3_below", 2'b00, 1'b1, 1'b1, 16'd6);
    rep(4, 16'h4000);
    expect_state("t4_inside", 2'b01, 1'b1, 1'b1, 16'd7);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h0000, 1'b0);
      expect_state("t4_gap_v", 2'b01, 1'b1, 1'b0, 16'd7);
      step(1'b0, 16'h0000, 1'b0);
      expect_state("t4_gap_i", 2'b01, 1'b1, 1'b0, 16'd7);
    end
    step(1'b1, 16'h0000, 1'b0);
    expect_state("t4_commit", 2'b00, 1'b1, 1'b1, 16'd8);
    step(1'b0, 16'h0000, 1'b0);
    expect_state("t4_after", 2'b00, 1'b1, 1'b0, 16'd8);
    rep(3, 16'h9000);
    step(1'b1, 16'h9000, 1'b1);
    expect_state("t5_clr_chg", 2'b10, 1'b1, 1'b1, 16'd1);
    step(1'b0, 16'h0000, 1'b1);
    expect_state("t5_clr_only", 2'b10, 1'b1, 1'b0, 16'd0);
    rep(1, 16'h4000);
    rep(3, 16'hA000);
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    expect_state("t6_reset", 2'b01, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    rep(3, 16'hA000);
    expect_state("t6_three", 2'b01, 1'b0, 1'b0, 16'd0);
    rep(1, 16'hA000);
    expect_state("t6_commit", 2'b10, 1'b1, 1'b1, 16'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/threshold_monitor_16bit.md
Name: threshold_monitor_16bit

Overview:
- Downstream consumer of the 16-bit magnitude compare stage.
- Classifies each incoming sample against a high and a low threshold into BELOW, INSIDE or ABOVE.
- Debounces the classification over N consecutive valid samples, then commits a zone.
- Reports each committed zone change with a one-cycle pulse and a saturating event counter, for the status/interrupt logic further down.

Parameters:
- WIDTH, 16, sample and threshold width (unsigned).
- DEBOUNCE, 4, consecutive agreeing valid samples required to commit a zone. Legal range 1..255. Run counter width = clog2(DEBOUNCE+1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_valid  input  1  sample is accepted on this edge when high. No backpressure.
- sample  input  WIDTH  value to classify.
- thr_hi  input  WIDTH  upper threshold, used combinationally on every accepted sample.
- thr_lo  input  WIDTH  lower threshold, used combinationally on every accepted sample.
- clear_count  input  1  zeroes event_count.
- zone  output  2  committed zone: 2'b00 BELOW, 2'b01 INSIDE, 2'b10 ABOVE. 2'b11 is never driven.
- zone_valid  output  1  high once any zone has been committed since reset.
- change_pulse  output  1  one-cycle pulse on each zone commit that changes zone or is the first commit.
- event_count  output  16  number of change_pulse events, saturating at 16'hFFFF.

Behaviour:
- Reset (rst=1 at edge): zone=2'b01, zone_valid=0, change_pulse=0, event_count=0; internal candidate=INSIDE, run count=0. Reset overrides all other inputs, including mid-debounce.
- Raw class of an accepted sample, unsigned compare, evaluated in this priority order:
  - sample > thr_hi -> ABOVE
  - else sample < thr_lo -> BELOW
  - else INSIDE
  - sample == thr_hi or sample == thr_lo -> INSIDE.
  - Misconfiguration (thr_lo > thr_hi) is resolved by the same priority; no error flag.
- Debounce, on each edge with sample_valid=1:
  - raw == candidate -> run count increments, saturating at DEBOUNCE.
  - raw != candidate -> candidate=raw, run count=1.
- sample_valid=0 cycles: candidate and run count hold; gaps do not break a run.
- Commit: on the edge where the accepted sample brings the run count to DEBOUNCE (or holds it at DEBOUNCE), the committed zone becomes candidate.
  - Committed outputs are visible the cycle after that edge.
  - Latency = 1 cycle after the DEBOUNCE-th agreeing sample.
- change_pulse:
  - Asserted for exactly one cycle, coincident with the updated zone, when the commit changes zone or when zone_valid was 0 (first commit, even if the zone is INSIDE).
  - Re-commits of the same zone produce no pulse.
- zone_valid: goes 1 with the first commit; stays 1 until reset.
- event_count:
  - Increments with each change_pulse; holds at 16'hFFFF.
  - clear_count=1 sets it to 0; if a change occurs on the same edge, the result is 1.
  - clear_count does not affect zone, zone_valid or the debounce state.
- DEBOUNCE=1: every accepted sample commits immediately, still with 1-cycle output latency.

Optional Feature:
- Macro THRESHOLD_MONITOR_STICKY_EN.
- Defined:
  - Adds outputs seen_above (1) and seen_below (1), sticky flags set on any ABOVE or BELOW commit.
  - Both cleared by rst and by clear_count.
  - Set wins over clear_count on the same edge.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan (DEBOUNCE=4, thr_hi=16'h8000, thr_lo=16'h1000):
1. Reset, then 4 consecutive valid samples 16'h4000 -> after the 4th edge: zone=01, zone_valid=1, change_pulse high for one cycle, event_count=1. Before that: zone=01, zone_valid=0.
2. Three samples 16'h9000, one sample 16'h4000, then four samples 16'h9000 -> no change after the first three. After the last four: zone=10, one change_pulse, event_count=2.
3. Boundaries, each as 4 consecutive samples:
   - 16'h8000 -> INSIDE, no pulse after commit of the same zone.
   - 16'h8001 -> ABOVE.
   - 16'h1000 -> INSIDE.
   - 16'h0FFF -> BELOW.
4. Four valid 16'h0000 samples interleaved with idle cycles over 8 cycles -> BELOW commits one cycle after the 4th valid sample; no pulse earlier.
5. clear_count asserted on the same edge as a committing change -> event_count=1. clear_count alone -> event_count=0, zone unchanged.
6. Three samples 16'hA000, then rst for 1 cycle, then three more 16'hA000 -> zone_valid stays 0. A fourth post-reset sample commits ABOVE with event_count=1.
